// File: rtl/cv32e40p_ft_pkg.sv
// Shared types and helpers for the fault-tolerant cv32e40p fault manager.
// Replica ids are 0..2; voter flag err_detected_<k+1> belongs to replica k.
package cv32e40p_ft_pkg;

  typedef enum logic [1:0] {
    TRIPLE = 2'd0,
    DUAL   = 2'd1,
    FAIL   = 2'd2
  } ft_state_e;

  typedef logic [1:0] replica_id_t;

  // Surviving replica ids in ascending order, packed as {sel_a, sel_b}.
  function automatic logic [3:0] survivors(input replica_id_t faulty);
    logic [3:0] ids;
    case (faulty)
      2'd0:    ids = {2'd1, 2'd2};
      2'd1:    ids = {2'd0, 2'd2};
      default: ids = {2'd0, 2'd1};
    endcase
    return ids;
  endfunction

endpackage

// File: rtl/cv32e40p_ft_err_counter.sv
// Leaky saturating per-replica error counter.
// cnt_o is the post-update value, so the threshold compare sees this cycle's event.
module cv32e40p_ft_err_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             freeze_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // An increment always beats a decay tick landing in the same cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (!freeze_i) begin
      if (inc_i) begin
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
      end else if (dec_i && (cnt_q != '0)) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_d;

endmodule

// File: rtl/cv32e40p_ft_fault_manager.sv
// Consumes majority-voter error flags, retires a persistently faulty replica
// by switching the voter to two-input mode, and flags exhaustion as sticky fatal.
module cv32e40p_ft_fault_manager
  import cv32e40p_ft_pkg::*;
#(
  parameter int CNT_W     = 4,
  parameter int THRESHOLD = 8,
  parameter int DECAY_W   = 10,
  parameter int TOT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             err_valid_i,
  input  logic             err_detected_1_i,
  input  logic             err_detected_2_i,
  input  logic             err_detected_3_i,
  input  logic             err_corrected_i,
  input  logic             clear_i,
  output logic             only_two_o,
  output logic [2:0]       disable_o,
  output logic [1:0]       sel_a_o,
  output logic [1:0]       sel_b_o,
  output logic             uncorr_o,
  output logic             fatal_o,
  output logic [TOT_W-1:0] tot_corr_o,
  output logic [1:0]       state_o
);

  ft_state_e        state_q, state_d;
  logic [2:0]       disable_q, disable_d;
  replica_id_t      sel_a_q, sel_a_d, sel_b_q, sel_b_d;
  logic             uncorr_q, uncorr_d;
  logic [TOT_W-1:0] tot_q, tot_d;
  logic [DECAY_W-1:0] timer_q;

  logic [2:0]       flags, inc, hit;
  logic [CNT_W-1:0] cnt [3];
  logic             all_three, decay, two_plus;
  replica_id_t      faulty;

  assign flags     = {err_detected_3_i, err_detected_2_i, err_detected_1_i};
  assign all_three = &flags;
  assign decay     = &timer_q;
  assign inc       = (err_valid_i && (state_q == TRIPLE) && !all_three) ? flags : 3'b000;

  for (genvar k = 0; k < 3; k++) begin : g_cnt
    cv32e40p_ft_err_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clr_i    (clear_i),
      .inc_i    (inc[k]),
      .dec_i    (decay),
      .freeze_i (disable_q[k]),
      .cnt_o    (cnt[k])
    );
    assign hit[k] = (cnt[k] >= CNT_W'(THRESHOLD));
  end

  assign two_plus = (hit[0] & hit[1]) | (hit[0] & hit[2]) | (hit[1] & hit[2]);
  assign faulty   = hit[0] ? 2'd0 : (hit[1] ? 2'd1 : 2'd2);

  always_comb begin
    state_d   = state_q;
    disable_d = disable_q;
    sel_a_d   = sel_a_q;
    sel_b_d   = sel_b_q;
    uncorr_d  = 1'b0;
    tot_d     = tot_q;
    if (clear_i) begin
      state_d   = TRIPLE;
      disable_d = 3'b000;
      sel_a_d   = 2'd0;
      sel_b_d   = 2'd1;
      tot_d     = '0;
    end else begin
      case (state_q)
        TRIPLE: begin
          if (err_valid_i && all_three) uncorr_d = 1'b1;
          if (err_valid_i && err_corrected_i && !all_three && (tot_q != '1))
            tot_d = tot_q + TOT_W'(1);
          if (two_plus) begin
            state_d = FAIL;
          end else if (|hit) begin
            state_d              = DUAL;
            disable_d            = hit;
            {sel_a_d, sel_b_d}   = survivors(faulty);
          end
        end
        // With only two voters left a mismatch cannot be attributed.
        DUAL: begin
          if (err_valid_i && (err_detected_1_i || err_detected_2_i)) begin
            state_d  = FAIL;
            uncorr_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= TRIPLE;
      disable_q <= 3'b000;
      sel_a_q   <= 2'd0;
      sel_b_q   <= 2'd1;
      uncorr_q  <= 1'b0;
      tot_q     <= '0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      disable_q <= disable_d;
      sel_a_q   <= sel_a_d;
      sel_b_q   <= sel_b_d;
      uncorr_q  <= uncorr_d;
      tot_q     <= tot_d;
      timer_q   <= clear_i ? '0 : timer_q + DECAY_W'(1);
    end
  end

  assign only_two_o = (state_q != TRIPLE);
  assign fatal_o    = (state_q == FAIL);
  assign disable_o  = disable_q;
  assign sel_a_o    = sel_a_q;
  assign sel_b_o    = sel_b_q;
  assign uncorr_o   = uncorr_q;
  assign tot_corr_o = tot_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_cv32e40p_ft_fault_manager.sv
// Scoreboard bench for the fault manager: a high-level reference model predicts
// the outputs of every cycle, and a monitor compares them one cycle later.
module tb_cv32e40p_ft_fault_manager;

  localparam int CNT_MAX      = 15;
  localparam int THR          = 8;
  localparam int DECAY_PERIOD = 1024;
  localparam int TOT_MAX      = 65535;

  typedef struct packed {
    logic [1:0]  st;
    logic        ot;
    logic [2:0]  dis;
    logic [1:0]  sa;
    logic [1:0]  sb;
    logic        unc;
    logic        fat;
    logic [15:0] tot;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i, err_valid_i, err_corrected_i, clear_i;
  logic        err_detected_1_i, err_detected_2_i, err_detected_3_i;
  logic        only_two_o, uncorr_o, fatal_o;
  logic [2:0]  disable_o;
  logic [1:0]  sel_a_o, sel_b_o, state_o;
  logic [15:0] tot_corr_o;

  always #5 clk_i = ~clk_i;

  cv32e40p_ft_fault_manager dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .err_valid_i      (err_valid_i),
    .err_detected_1_i (err_detected_1_i),
    .err_detected_2_i (err_detected_2_i),
    .err_detected_3_i (err_detected_3_i),
    .err_corrected_i  (err_corrected_i),
    .clear_i          (clear_i),
    .only_two_o       (only_two_o),
    .disable_o        (disable_o),
    .sel_a_o          (sel_a_o),
    .sel_b_o          (sel_b_o),
    .uncorr_o         (uncorr_o),
    .fatal_o          (fatal_o),
    .tot_corr_o       (tot_corr_o),
    .state_o          (state_o)
  );

  exp_t exp_q[$];
  int   vec_cnt = 0;
  int   miscompares = 0;

  // Reference model: mode 0 = three replicas, 1 = two replicas, 2 = exhausted.
  int       m_cnt[3];
  int       m_mode, m_tot, m_tick, m_sa, m_sb;
  bit [2:0] m_dis;
  bit       m_unc;

  function automatic exp_t mkExp(int st, int ot, int dis, int sa, int sb, int unc, int fat, int tot);
    exp_t e;
    e.st = 2'(st); e.ot = 1'(ot); e.dis = 3'(dis); e.sa = 2'(sa); e.sb = 2'(sb);
    e.unc = 1'(unc); e.fat = 1'(fat); e.tot = 16'(tot);
    return e;
  endfunction

  function automatic string fmtExp(exp_t e);
    return $sformatf("st=%0d two=%0b dis=%b sa=%0d sb=%0d unc=%0b fat=%0b tot=%0d",
                     e.st, e.ot, e.dis, e.sa, e.sb, e.unc, e.fat, e.tot);
  endfunction

  function automatic exp_t dutOut();
    return mkExp(int'(state_o), int'(only_two_o), int'(disable_o), int'(sel_a_o), int'(sel_b_o),
                 int'(uncorr_o), int'(fatal_o), int'(tot_corr_o));
  endfunction

  function automatic exp_t modelOut();
    return mkExp(m_mode, (m_mode != 0) ? 1 : 0, int'(m_dis), m_sa, m_sb, int'(m_unc),
                 (m_mode == 2) ? 1 : 0, m_tot);
  endfunction

  function automatic void modelReset();
    for (int k = 0; k < 3; k++) m_cnt[k] = 0;
    m_mode = 0; m_tot = 0; m_tick = 0; m_sa = 0; m_sb = 1; m_dis = 3'b000; m_unc = 1'b0;
  endfunction

  function automatic void modelStep(bit r, bit c, bit v, bit [2:0] f);
    bit dec;
    int hits, hk, s;
    if (r || c) begin
      modelReset();
      return;
    end
    dec = (m_tick % DECAY_PERIOD) == DECAY_PERIOD - 1;
    m_tick++;
    m_unc = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (m_dis[k]) continue;
      if (m_mode == 0 && v && f != 3'b111 && f[k]) m_cnt[k] = (m_cnt[k] < CNT_MAX) ? m_cnt[k] + 1 : CNT_MAX;
      else if (dec && m_cnt[k] > 0) m_cnt[k]--;
    end
    if (m_mode == 0) begin
      if (v && f == 3'b111) m_unc = 1'b1;
      else if (v && f != 3'b000 && m_tot < TOT_MAX) m_tot++;
      hits = 0; hk = 0;
      for (int k = 0; k < 3; k++) if (m_cnt[k] >= THR) begin hits++; hk = k; end
      if (hits >= 2) m_mode = 2;
      else if (hits == 1) begin
        m_mode = 1;
        m_dis = 3'b001 << hk;
        s = 0;
        for (int k = 0; k < 3; k++) if (k != hk) begin
          if (s == 0) m_sa = k; else m_sb = k;
          s++;
        end
      end
    end else if (m_mode == 1) begin
      if (v && (f[0] || f[1])) begin m_mode = 2; m_unc = 1'b1; end
    end
  endfunction

  task automatic compare(string name, exp_t got, exp_t want);
    vec_cnt++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %s, want %s", name, fmtExp(got), fmtExp(want));
    end
  endtask

  // One cycle of stimulus; the predicted post-edge outputs go to the scoreboard.
  task automatic applyStimulus(bit r, bit c, bit v, bit [2:0] f);
    @(negedge clk_i);
    rst_i = r; clear_i = c; err_valid_i = v;
    {err_detected_3_i, err_detected_2_i, err_detected_1_i} = f;
    err_corrected_i = (f != 3'b000) && (f != 3'b111);
    modelStep(r, c, v, f);
    exp_q.push_back(modelOut());
  endtask

  task automatic checkOutput(string name, exp_t want);
    @(posedge clk_i);
    #2;
    compare(name, dutOut(), want);
  endtask

  initial begin
    exp_t w;
    forever begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        compare($sformatf("cycle@%0t", $time), dutOut(), w);
      end
    end
  end

  initial begin
    exp_t rst_exp;
    bit r, c, v;
    bit [2:0] f;
    int sel;
    rst_exp = mkExp(0, 0, 3'b000, 0, 1, 0, 0, 0);
    rst_i = 1'b1; clear_i = 1'b0; err_valid_i = 1'b0; err_corrected_i = 1'b0;
    err_detected_1_i = 1'b0; err_detected_2_i = 1'b0; err_detected_3_i = 1'b0;
    modelReset();

    applyStimulus(1, 0, 0, 3'b000);
    applyStimulus(1, 0, 0, 3'b000);
    checkOutput("reset", rst_exp);

    for (int i = 0; i < 7; i++) applyStimulus(0, 0, 1, 3'b010);
    checkOutput("seven_hits", mkExp(0, 0, 3'b000, 0, 1, 0, 0, 7));
    applyStimulus(0, 0, 1, 3'b010);
    checkOutput("enter_dual", mkExp(1, 1, 3'b010, 0, 2, 0, 0, 8));
    applyStimulus(0, 0, 1, 3'b011);
    checkOutput("dual_uncorr", mkExp(2, 1, 3'b010, 0, 2, 1, 1, 8));
    applyStimulus(0, 0, 1, 3'b001);
    checkOutput("fail_sticky", mkExp(2, 1, 3'b010, 0, 2, 0, 1, 8));
    applyStimulus(0, 1, 0, 3'b000);
    checkOutput("clear_from_fail", rst_exp);

    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 1, 3'b101);
    checkOutput("double_threshold", mkExp(2, 1, 3'b000, 0, 1, 0, 1, 8));
    applyStimulus(0, 1, 0, 3'b000);

    applyStimulus(0, 0, 1, 3'b001);
    applyStimulus(0, 0, 0, 3'b111);
    applyStimulus(0, 0, 1, 3'b111);
    checkOutput("all_three", mkExp(0, 0, 3'b000, 0, 1, 1, 0, 1));
    applyStimulus(0, 0, 0, 3'b000);
    checkOutput("uncorr_one_cycle", mkExp(0, 0, 3'b000, 0, 1, 0, 0, 1));

    // Decay: 3 -> 2 on the first wrap, then an increment on the second wrap wins.
    applyStimulus(0, 1, 0, 3'b000);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 3'b001);
    while ((m_tick % DECAY_PERIOD) != DECAY_PERIOD - 1) applyStimulus(0, 0, 0, 3'b000);
    applyStimulus(0, 0, 0, 3'b000);
    while ((m_tick % DECAY_PERIOD) != DECAY_PERIOD - 1) applyStimulus(0, 0, 0, 3'b000);
    applyStimulus(0, 0, 1, 3'b001);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 3'b001);
    checkOutput("decay_count7", mkExp(0, 0, 3'b000, 0, 1, 0, 0, 8));
    applyStimulus(0, 0, 1, 3'b001);
    checkOutput("decay_dual", mkExp(1, 1, 3'b001, 1, 2, 0, 0, 9));

    // Asynchronous reset while in DUAL with nine corrected errors.
    @(negedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    compare("async_reset", dutOut(), rst_exp);
    applyStimulus(1, 0, 0, 3'b000);
    applyStimulus(1, 0, 0, 3'b000);

    for (int i = 0; i < 2500; i++) begin
      r = ($urandom_range(0, 299) == 0);
      c = ($urandom_range(0, 79) == 0);
      v = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      if (sel < 6)       f = 3'b001 << $urandom_range(0, 2);
      else if (sel == 6) f = 3'b000;
      else if (sel == 7) f = 3'b111;
      else               f = 3'($urandom_range(0, 7));
      applyStimulus(r, c, v, f);
    end

    @(posedge clk_i);
    #3;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
